// File: rtl/layer_ctrl_pkg.sv
// Shared types and width helpers for the layer_M_N_P_T control path.
package layer_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    // Counter/select width that never collapses to zero bits for a range of 1.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX up-counter with async active-low reset and a terminal-count flag.
module mod_counter
    import layer_ctrl_pkg::*;
#(
    parameter  int unsigned MAX = 2,
    localparam int unsigned CW  = clog2_min1(MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CW'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign last  = w_last;

endmodule

// File: rtl/layer_ctrl.sv
// Control FSM for a matrix-vector layer: loads N inputs, sequences M/P row
// groups through P MAC lanes, then streams the P lane results per group.
module layer_ctrl
    import layer_ctrl_pkg::*;
#(
    parameter  int unsigned M  = 4,
    parameter  int unsigned N  = 3,
    parameter  int unsigned P  = 2,
    localparam int unsigned XW = $clog2(N),
    localparam int unsigned WW = $clog2(N * M / P),
    localparam int unsigned SW = clog2_min1(P)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          x_we,
    output logic [XW-1:0] x_addr,
    output logic [WW-1:0] w_addr,
    output logic          clr_acc,
    output logic          en_acc,
    output logic [SW-1:0] out_sel
);

    localparam int unsigned G  = M / P;
    localparam int unsigned GW = clog2_min1(G);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_en_acc;

    logic [XW-1:0] w_k;
    logic [GW-1:0] w_g;
    logic [SW-1:0] w_o;
    logic          w_k_last;
    logic          w_g_last;
    logic          w_o_last;
    logic          w_k_inc;
    logic          w_g_inc;
    logic          w_o_inc;

    logic          w_s_ready;
    logic          w_x_we;

    assign w_s_ready = (r_state == LOAD) & reset;
    assign w_x_we    = s_valid & w_s_ready;

    mod_counter #(.MAX(N)) u_cnt_k (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_k_inc),
        .count (w_k),
        .last  (w_k_last)
    );

    // g wraps to 0 on the final group's last handshake, so the next vector
    // starts at group 0 without a separate clear.
    mod_counter #(.MAX(G)) u_cnt_g (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_g_inc),
        .count (w_g),
        .last  (w_g_last)
    );

    mod_counter #(.MAX(P)) u_cnt_o (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_o_inc),
        .count (w_o),
        .last  (w_o_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= LOAD;
            r_en_acc <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Accumulate one cycle behind the address to cover ROM/buffer read latency.
            r_en_acc <= (r_state == COMPUTE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_inc     = 1'b0;
        w_g_inc     = 1'b0;
        w_o_inc     = 1'b0;
        case (r_state)
            LOAD: begin
                w_k_inc = w_x_we;
                if (w_x_we && w_k_last) begin
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                w_k_inc = 1'b1;
                if (w_k_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = OUTPUT;
            end
            OUTPUT: begin
                if (m_ready) begin
                    w_o_inc = 1'b1;
                    if (w_o_last) begin
                        w_g_inc     = 1'b1;
                        w_state_nxt = w_g_last ? LOAD : COMPUTE;
                    end
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    assign s_ready = w_s_ready;
    assign x_we    = w_x_we;
    assign m_valid = (r_state == OUTPUT);
    assign x_addr  = w_k;
    assign w_addr  = WW'(w_g) * WW'(N) + WW'(w_k);
    assign clr_acc = (r_state == COMPUTE) && (w_k == '0);
    assign en_acc  = r_en_acc;
    assign out_sel = w_o;

endmodule

// File: tb/tb_layer_ctrl.sv
// Directed bench for layer_ctrl (M=4, N=3, P=2) with an address/output scoreboard.
module tb_layer_ctrl;

    localparam int unsigned M = 4;
    localparam int unsigned N = 3;
    localparam int unsigned P = 2;
    localparam int unsigned G = M / P;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic       m_ready;
    logic       s_ready;
    logic       m_valid;
    logic       x_we;
    logic [1:0] x_addr;
    logic [2:0] w_addr;
    logic       clr_acc;
    logic       en_acc;
    logic [0:0] out_sel;

    typedef struct {
        int unsigned w;
        int unsigned x;
        bit          clr;
    } cmp_t;

    cmp_t        cmp_q[$];
    int unsigned sel_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    layer_ctrl #(.M(M), .N(N), .P(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .x_we    (x_we),
        .x_addr  (x_addr),
        .w_addr  (w_addr),
        .clr_acc (clr_acc),
        .en_acc  (en_acc),
        .out_sel (out_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_vector();
        cmp_t e;
        for (int unsigned g = 0; g < G; g++) begin
            for (int unsigned k = 0; k < N; k++) begin
                e.w   = g * N + k;
                e.x   = k;
                e.clr = (k == 0);
                cmp_q.push_back(e);
            end
            for (int unsigned o = 0; o < P; o++) sel_q.push_back(o);
        end
    endtask

    task automatic check_reset_outputs(input string ctx);
        check({ctx, "_s_ready"}, 32'(s_ready), 32'd0);
        check({ctx, "_m_valid"}, 32'(m_valid), 32'd0);
        check({ctx, "_x_we"},    32'(x_we),    32'd0);
        check({ctx, "_clr_acc"}, 32'(clr_acc), 32'd0);
        check({ctx, "_en_acc"},  32'(en_acc),  32'd0);
        check({ctx, "_x_addr"},  32'(x_addr),  32'd0);
        check({ctx, "_w_addr"},  32'(w_addr),  32'd0);
        check({ctx, "_out_sel"}, 32'(out_sel), 32'd0);
    endtask

    task automatic drive_load(input logic v, input int unsigned idx);
        s_valid = v;
        #1;
        check("load_s_ready", 32'(s_ready), 32'd1);
        check("load_x_we",    32'(x_we),    32'(v));
        check("load_x_addr",  32'(x_addr),  idx);
        check("load_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_compute_step(input int unsigned k);
        cmp_t e;
        #1;
        if (cmp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_cmp: observed empty queue expected entry for k=%0d", k);
        end else begin
            e = cmp_q.pop_front();
            check("cmp_w_addr",  32'(w_addr),  e.w);
            check("cmp_x_addr",  32'(x_addr),  e.x);
            check("cmp_clr_acc", 32'(clr_acc), 32'(e.clr));
            check("cmp_en_acc",  32'(en_acc),  32'(k != 0));
            check("cmp_s_ready", 32'(s_ready), 32'd0);
            check("cmp_m_valid", 32'(m_valid), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic run_groups(input int unsigned bp);
        for (int unsigned g = 0; g < G; g++) begin
            for (int unsigned k = 0; k < N; k++) check_compute_step(k);
            #1;
            check("drain_en_acc",  32'(en_acc),  32'd1);
            check("drain_clr_acc", 32'(clr_acc), 32'd0);
            check("drain_m_valid", 32'(m_valid), 32'd0);
            @(negedge clk);
            if (g == 0 && bp > 0) begin
                m_ready = 1'b0;
                repeat (bp) begin
                    #1;
                    check("bp_m_valid", 32'(m_valid), 32'd1);
                    check("bp_en_acc",  32'(en_acc),  32'd0);
                    if (sel_q.size() != 0) check("bp_out_sel", 32'(out_sel), sel_q[0]);
                    @(negedge clk);
                end
            end
            for (int unsigned o = 0; o < P; o++) begin
                m_ready = 1'b1;
                #1;
                check("out_m_valid", 32'(m_valid), 32'd1);
                if (sel_q.size() == 0) begin
                    n_fail++;
                    $error("FAIL sb_sel: observed empty queue expected entry for o=%0d", o);
                end else begin
                    check("out_sel", 32'(out_sel), sel_q.pop_front());
                end
                @(negedge clk);
            end
            m_ready = 1'b0;
        end
        #1;
        check("done_s_ready", 32'(s_ready), 32'd1);
        check("done_x_addr",  32'(x_addr),  32'd0);
        check("done_m_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmp_t e;
        reset   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1 reset = 1'b0;

        // Reset held across three edges, with s_valid asserted to prove gating.
        repeat (3) begin
            @(negedge clk);
            s_valid = 1'b1;
            #1 check_reset_outputs("rst");
        end
        s_valid = 1'b0;
        reset   = 1'b1;
        #1;
        check("rel_s_ready", 32'(s_ready), 32'd1);
        check("rel_x_addr",  32'(x_addr),  32'd0);
        check("rel_x_we",    32'(x_we),    32'd0);
        @(negedge clk);

        // Vector 1: load with a gap, backpressure on the first output.
        push_vector();
        drive_load(1'b1, 0);
        drive_load(1'b0, 1);
        drive_load(1'b1, 1);
        drive_load(1'b1, 2);
        s_valid = 1'b0;
        run_groups(5);

        // Vector 2: back-to-back load, no backpressure.
        @(negedge clk);
        push_vector();
        for (int unsigned i = 0; i < N; i++) drive_load(1'b1, i);
        s_valid = 1'b0;
        run_groups(0);

        // Vector 3: abort with async reset during COMPUTE at k=1.
        @(negedge clk);
        push_vector();
        for (int unsigned i = 0; i < N; i++) drive_load(1'b1, i);
        s_valid = 1'b0;
        check_compute_step(0);
        #1;
        e = cmp_q.pop_front();
        check("abort_w_addr", 32'(w_addr), e.w);
        check("abort_en_acc", 32'(en_acc), 32'd1);
        #1 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        cmp_q.delete();
        sel_q.delete();
        @(negedge clk);
        #1 check_reset_outputs("midrst_hold");
        reset = 1'b1;
        #1;
        check("rel2_s_ready", 32'(s_ready), 32'd1);
        check("rel2_x_addr",  32'(x_addr),  32'd0);
        @(negedge clk);

        // Partial vector must not trigger any compute or output.
        drive_load(1'b1, 0);
        drive_load(1'b1, 1);
        s_valid = 1'b0;
        repeat (6) begin
            #1;
            check("partial_m_valid", 32'(m_valid), 32'd0);
            check("partial_s_ready", 32'(s_ready), 32'd1);
            check("partial_x_addr",  32'(x_addr),  32'd2);
            check("partial_en_acc",  32'(en_acc),  32'd0);
            @(negedge clk);
        end
        push_vector();
        drive_load(1'b1, 2);
        s_valid = 1'b0;
        run_groups(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
